// File: rtl/lab5_hexscan_display_if.sv
// Bus between the data-memory output ports and the hex scan display.
// The master side drives the IO bytes and BLANK; the slave (display) drives the
// anode/segment outputs plus the slot index and frame strobe.
interface lab5_hexscan_display_if;
   logic [7:0] IOD;
   logic [7:0] IOE;
   logic [7:0] IOF;
   logic [7:0] IOG;
   logic       BLANK;
   logic [7:0] AN_L;
   logic [6:0] SEG_L;
   logic       DP_L;
   logic [2:0] DIGIT;
   logic       FRAME;

   modport master (
      output IOD, IOE, IOF, IOG, BLANK,
      input  AN_L, SEG_L, DP_L, DIGIT, FRAME
   );

   modport slave (
      input  IOD, IOE, IOF, IOG, BLANK,
      output AN_L, SEG_L, DP_L, DIGIT, FRAME
   );
endinterface

// File: rtl/lab5_hexscan_display.sv
// 8-digit multiplexed common-anode hex display for {IOG,IOF,IOE,IOD}.
// Each digit slot lasts REFRESH_DIV cycles and opens with DEAD_CYC cycles of
// all anodes off. The value is copied into a shadow register once per frame so
// a scan never mixes two values.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module lab5_hexscan_display #(
   parameter int REFRESH_DIV = 1024,
   parameter int DEAD_CYC    = 16
) (
   input  logic                    CLK,
   input  logic                    RESET,
   lab5_hexscan_display_if.slave   io
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic [2:0]    digit;
   logic [31:0]   shadow;
   logic          frame;
   logic [7:0]    an_l;
   logic [6:0]    seg_l;
   logic          dp_l;

   logic          terminal;
   logic          frame_end;
   logic [31:0]   new_val;
   logic [4:0]    nib_base;
   logic [3:0]    nibble;
   logic          suppressed;
   logic          dark;
   logic [7:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   assign terminal  = (div_cnt == TERM);
   assign frame_end = terminal && (digit == 3'd7);
   assign new_val   = {io.IOG, io.IOF, io.IOE, io.IOD};
   assign nib_base  = {digit, 2'b00};
   assign nibble    = shadow[nib_base +: 4];

   // Hex glyphs, active low, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   logic [7:0] sup_mask;
   logic [7:0] sup_next;
   logic       zero_run;

   // Digit n is suppressed while it and every higher digit are zero; digit 0 always shows.
   always_comb begin
      sup_next = 8'h00;
      zero_run = 1'b1;
      for (int n = 7; n >= 1; n--) begin
         zero_run    = zero_run && (new_val[4*n +: 4] == 4'h0);
         sup_next[n] = zero_run;
      end
   end

   // Mask is captured together with the shadow; its reset value matches shadow=0.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         sup_mask <= 8'hFE;
      else if (frame_end)
         sup_mask <= sup_next;
   end

   assign suppressed = sup_mask[digit];
`else
   assign suppressed = 1'b0;
`endif

   // Anodes go dark for BLANK, the slot's dead time, or a suppressed digit.
   always_comb begin
      dark     = io.BLANK || (int'(div_cnt) < DEAD_CYC) || suppressed;
      an_next  = dark ? 8'hFF : ~(8'b1 << digit);
      seg_next = hex7(nibble);
      dp_next  = dark ? 1'b1 : !((digit == 3'd2) || (digit == 3'd4) || (digit == 3'd6));
   end

   // Slot divider, digit index and once-per-frame shadow capture.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         div_cnt <= '0;
         digit   <= 3'd0;
         shadow  <= 32'h0;
         frame   <= 1'b0;
      end else begin
         frame <= frame_end;
         if (terminal) begin
            div_cnt <= '0;
            digit   <= digit + 3'd1;
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
         if (frame_end)
            shadow <= new_val;
      end
   end

   // Display drivers are registered, one cycle behind the slot state.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         an_l  <= 8'hFF;
         seg_l <= 7'h7F;
         dp_l  <= 1'b1;
      end else begin
         an_l  <= an_next;
         seg_l <= seg_next;
         dp_l  <= dp_next;
      end
   end

   assign io.AN_L  = an_l;
   assign io.SEG_L = seg_l;
   assign io.DP_L  = dp_l;
   assign io.DIGIT = digit;
   assign io.FRAME = frame;

endmodule

// File: tb/tb_lab5_hexscan_display.sv
// Directed bench for lab5_hexscan_display with REFRESH_DIV=4, DEAD_CYC=1.
// Outputs are sampled on the falling edge. After a FRAME sample, the k-th
// following falling edge shows slot s=((k-1)/4)%8, phase p=(k-1)%4, with
// DIGIT=(k/4)%8 and FRAME high when k is a multiple of 32.
module tb_lab5_hexscan_display;

   logic CLK = 1'b0;
   logic RESET;
   int   n_tests = 0;
   int   n_fail  = 0;

   lab5_hexscan_display_if bus();

   lab5_hexscan_display #(.REFRESH_DIV(4), .DEAD_CYC(1)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .io    (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   function automatic bit shown(input logic [31:0] v, input int s);
`ifdef LEADING_ZERO_BLANK_EN
      logic [31:0] hi;
      if (s == 0) return 1'b1;
      hi = v >> (4 * s);
      return hi != 32'h0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [3:0] nib(input logic [31:0] v, input int s);
      logic [31:0] t;
      t = v >> (4 * s);
      return t[3:0];
   endfunction

   task automatic set_val(input logic [31:0] v);
      {bus.IOG, bus.IOF, bus.IOE, bus.IOD} = v;
   endtask

   task automatic wait_frame(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge CLK);
         seen = (bus.FRAME === 1'b1);
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: FRAME not seen within 40 cycles", name);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      bus.BLANK = 1'b0;
      set_val(32'h0);
      repeat (3) @(negedge CLK);
      n_tests++;
      if ({bus.AN_L, bus.SEG_L, bus.DP_L, bus.FRAME, bus.DIGIT} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_hold: got AN=%h SEG=%b DP=%b FR=%b DG=%0d", bus.AN_L, bus.SEG_L, bus.DP_L, bus.FRAME, bus.DIGIT);
      end
      RESET = 1'b1;
      repeat (14) @(negedge CLK);
      n_tests++;
      if (bus.AN_L !== 8'hF7 || bus.DIGIT !== 3'd3) begin
         n_fail++;
         $display("FAIL pre_reset_run: got AN=%h DG=%0d exp AN=f7 DG=3", bus.AN_L, bus.DIGIT);
      end
      #2 RESET = 1'b0;
      #1;
      n_tests++;
      if ({bus.AN_L, bus.SEG_L, bus.DP_L, bus.FRAME, bus.DIGIT} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL async_reset: got AN=%h SEG=%b DP=%b FR=%b DG=%0d", bus.AN_L, bus.SEG_L, bus.DP_L, bus.FRAME, bus.DIGIT);
      end
      @(negedge CLK);
      n_tests++;
      if ({bus.AN_L, bus.DIGIT} !== {8'hFF, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_held_edge: got AN=%h DG=%0d exp AN=ff DG=0", bus.AN_L, bus.DIGIT);
      end
   endtask

   task automatic test_free_run();
      int s, p;
      logic [7:0] ea;
      logic       ed;
      RESET = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         s  = ((k - 1) / 4) % 8;
         p  = (k - 1) % 4;
         ea = (p == 0 || !shown(32'h0, s)) ? 8'hFF : ~(8'b1 << s);
         ed = (ea != 8'hFF && (s == 2 || s == 4 || s == 6)) ? 1'b0 : 1'b1;
         n_tests++;
         if (bus.AN_L !== ea) begin
            n_fail++;
            $display("FAIL free_run_an k=%0d: got %h exp %h", k, bus.AN_L, ea);
         end
         n_tests++;
         if (bus.SEG_L !== 7'b1000000 || bus.DP_L !== ed) begin
            n_fail++;
            $display("FAIL free_run_seg k=%0d: got SEG=%b DP=%b exp SEG=1000000 DP=%b", k, bus.SEG_L, bus.DP_L, ed);
         end
         n_tests++;
         if (bus.DIGIT !== 3'((k / 4) % 8) || bus.FRAME !== (k % 32 == 0)) begin
            n_fail++;
            $display("FAIL free_run_cadence k=%0d: got DG=%0d FR=%b exp DG=%0d FR=%b", k, bus.DIGIT, bus.FRAME, (k / 4) % 8, (k % 32 == 0));
         end
      end
   endtask

   task automatic test_digits();
      logic [31:0] vals [4];
      int s, p;
      logic [7:0] ea;
      logic [6:0] es;
      logic       ed;
      vals = '{32'h00000021, 32'h76543210, 32'hFEDCBA98, 32'h00000A05};
      for (int v = 0; v < 4; v++) begin
         set_val(vals[v]);
         wait_frame("digits_sync");
         for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            s  = ((k - 1) / 4) % 8;
            p  = (k - 1) % 4;
            ea = (p == 0 || !shown(vals[v], s)) ? 8'hFF : ~(8'b1 << s);
            es = glyph(nib(vals[v], s));
            ed = (ea != 8'hFF && (s == 2 || s == 4 || s == 6)) ? 1'b0 : 1'b1;
            n_tests++;
            if (bus.AN_L !== ea || bus.SEG_L !== es || bus.DP_L !== ed) begin
               n_fail++;
               $display("FAIL digits val=%h k=%0d: got AN=%h SEG=%b DP=%b exp AN=%h SEG=%b DP=%b",
                        vals[v], k, bus.AN_L, bus.SEG_L, bus.DP_L, ea, es, ed);
            end
         end
      end
   endtask

   task automatic test_midframe_change();
      int s, p;
      logic [31:0] val;
      logic [7:0]  ea;
      logic [6:0]  es;
      set_val(32'h00000021);
      wait_frame("midframe_sync");
      for (int k = 1; k <= 64; k++) begin
         @(negedge CLK);
         s   = ((k - 1) / 4) % 8;
         p   = (k - 1) % 4;
         val = (k <= 32) ? 32'h00000021 : 32'h000000FF;
         ea  = (p == 0 || !shown(val, s)) ? 8'hFF : ~(8'b1 << s);
         es  = glyph(nib(val, s));
         n_tests++;
         if (bus.AN_L !== ea || bus.SEG_L !== es || bus.FRAME !== (k % 32 == 0)) begin
            n_fail++;
            $display("FAIL midframe k=%0d: got AN=%h SEG=%b FR=%b exp AN=%h SEG=%b FR=%b",
                     k, bus.AN_L, bus.SEG_L, bus.FRAME, ea, es, (k % 32 == 0));
         end
         if (k == 2) bus.IOD = 8'hFF;
      end
   endtask

   task automatic test_blank();
      int s, p;
      bit blk;
      logic [7:0] ea;
      logic       ed;
      wait_frame("blank_sync");
      bus.BLANK = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge CLK);
         s   = ((k - 1) / 4) % 8;
         p   = (k - 1) % 4;
         blk = (k <= 34);
         ea  = (blk || p == 0 || !shown(32'hFF, s)) ? 8'hFF : ~(8'b1 << s);
         ed  = (ea != 8'hFF && (s == 2 || s == 4 || s == 6)) ? 1'b0 : 1'b1;
         n_tests++;
         if (bus.AN_L !== ea || bus.DP_L !== ed) begin
            n_fail++;
            $display("FAIL blank k=%0d: got AN=%h DP=%b exp AN=%h DP=%b", k, bus.AN_L, bus.DP_L, ea, ed);
         end
         n_tests++;
         if (bus.DIGIT !== 3'((k / 4) % 8) || bus.FRAME !== (k % 32 == 0)) begin
            n_fail++;
            $display("FAIL blank_cadence k=%0d: got DG=%0d FR=%b exp DG=%0d FR=%b", k, bus.DIGIT, bus.FRAME, (k / 4) % 8, (k % 32 == 0));
         end
         if (k == 34) bus.BLANK = 1'b0;
      end
      n_tests++;
      if (bus.SEG_L !== 7'b0001110) begin
         n_fail++;
         $display("FAIL blank_restore_seg: got %b exp 0001110", bus.SEG_L);
      end
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   task automatic test_lzb();
      logic [31:0] vals [2];
      logic [7:0]  lit  [2];
      int s, p;
      logic [7:0] ea;
      vals = '{32'h00000A05, 32'h00000000};
      lit  = '{8'h07, 8'h01};
      for (int v = 0; v < 2; v++) begin
         set_val(vals[v]);
         wait_frame("lzb_sync");
         for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            s  = ((k - 1) / 4) % 8;
            p  = (k - 1) % 4;
            ea = (p == 0 || !lit[v][s]) ? 8'hFF : ~(8'b1 << s);
            n_tests++;
            if (bus.AN_L !== ea || (ea == 8'hFF && bus.DP_L !== 1'b1)) begin
               n_fail++;
               $display("FAIL lzb val=%h k=%0d: got AN=%h DP=%b exp AN=%h", vals[v], k, bus.AN_L, bus.DP_L, ea);
            end
            if (p != 0 && s < 2) begin
               n_tests++;
               if (bus.SEG_L !== ((s == 0 && v == 0) ? 7'b0010010 : 7'b1000000)) begin
                  n_fail++;
                  $display("FAIL lzb_seg val=%h slot=%0d: got %b", vals[v], s, bus.SEG_L);
               end
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_free_run();
      test_digits();
      test_midframe_change();
      test_blank();
`ifdef LEADING_ZERO_BLANK_EN
      test_lzb();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
